pipelined_addsub: RTL

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the combinational ripple adder.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/rca_segment.sv | 27 ++
 rtl/pipelined_addsub.sv | 122 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared configuration helpers and result type for the pipelined adder/subtractor.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  function automatic int unsigned seg_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
  } addsub_result_t;

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry segment built from a chain of full adders.
module rca_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  // Carries live in per-bit blocks so each link of the chain is its own net.
  for (genvar i = 0; i < SEG; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_link
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_fa[SEG-1].co;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per register stage,
// with a global advance enable for valid/ready flow control.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned SEG = seg_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic             v_d [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  logic adv;

  assign adv      = ~v_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Each stage carries full-width operand/sum words; stage k only rewrites its own segment.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic [WIDTH-1:0] s_nxt;

    if (k == 0) begin : g_head
      assign src_a = in_a;
      assign src_b = in_sub ? ~in_b : in_b;
      assign src_s = '0;
      assign src_c = in_sub | in_cin;
      assign src_v = in_valid;
    end else begin : g_body
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_s = s_q[k-1];
      assign src_c = c_q[k-1];
      assign src_v = v_q[k-1];
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a    (src_a[k*SEG +: SEG]),
      .b    (src_b[k*SEG +: SEG]),
      .cin  (src_c),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      s_nxt                = src_s;
      s_nxt[k*SEG +: SEG]  = seg_sum;
    end

    assign v_d[k] = src_v;
    assign c_d[k] = seg_cout;
    assign a_d[k] = src_a;
    assign b_d[k] = src_b;
    assign s_d[k] = s_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                     (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

  // Only the operand sign bits are needed past the last segment.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule
